// File: rtl/id_ex_fwd_reg_if.sv
// ID/EX boundary bundle: ID-stage operands and control in, EX-stage latched
// outputs, forwarding selects and the load-use stall request out.
interface id_ex_fwd_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // pipeline control
  logic                      stall;
  logic                      flush;
  // ID-stage instruction
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     id_rs_data;
  logic [DATA_WIDTH-1:0]     id_rt_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic                      id_reg_write;
  logic                      id_mem_read;
  // downstream stage destinations
  logic                      exmem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] exmem_rd;
  logic                      memwb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] memwb_rd;
  logic [DATA_WIDTH-1:0]     memwb_data;
  // EX-stage outputs
  logic                      ex_valid;
  logic [DATA_WIDTH-1:0]     ex_rs_data;
  logic [DATA_WIDTH-1:0]     ex_rt_data;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic [1:0]                ex_fwd_a_sel;
  logic [1:0]                ex_fwd_b_sel;
  logic                      load_use_hazard;

  // pipeline register side
  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_reg_write, id_mem_read, exmem_reg_write, exmem_rd,
           memwb_reg_write, memwb_rd, memwb_data,
    output ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_reg_write,
           ex_mem_read, ex_fwd_a_sel, ex_fwd_b_sel, load_use_hazard
  );

  // pipeline driver side
  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_reg_write, id_mem_read, exmem_reg_write, exmem_rd,
           memwb_reg_write, memwb_rd, memwb_data,
    input  ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rd, ex_reg_write,
           ex_mem_read, ex_fwd_a_sel, ex_fwd_b_sel, load_use_hazard
  );
endinterface

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with WB->ID regfile bypass, registered EX-stage
// forwarding mux selects and self-inserted load-use bubbles.
module id_ex_fwd_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_fwd_reg_if.slave    bus
);

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [REG_ADDR_WIDTH-1:0] R0 = '0;

  logic                      ex_valid_q,     ex_valid_d;
  logic                      ex_reg_write_q, ex_reg_write_d;
  logic                      ex_mem_read_q,  ex_mem_read_d;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_q,        ex_rd_d;
  logic [DATA_WIDTH-1:0]     ex_rs_data_q,   ex_rs_data_d;
  logic [DATA_WIDTH-1:0]     ex_rt_data_q,   ex_rt_data_d;
  logic [DATA_WIDTH-1:0]     ex_imm_q,       ex_imm_d;
  logic [1:0]                ex_fwd_a_sel_q, ex_fwd_a_sel_d;
  logic [1:0]                ex_fwd_b_sel_q, ex_fwd_b_sel_d;

  // Source operands indexed 0 = A (rs), 1 = B (rt) so both paths share one body.
  logic [REG_ADDR_WIDTH-1:0] src_idx  [2];
  logic [DATA_WIDTH-1:0]     src_data [2];
  logic [DATA_WIDTH-1:0]     byp_data [2];
  logic [1:0]                fwd_sel  [2];
  logic                      hazard;

  assign src_idx[0]  = bus.id_rs;
  assign src_idx[1]  = bus.id_rt;
  assign src_data[0] = bus.id_rs_data;
  assign src_data[1] = bus.id_rt_data;

  // A load in EX whose result an ID source needs cannot be forwarded in time.
  assign hazard = ex_valid_q & ex_mem_read_q & bus.id_valid & (ex_rd_q != R0) &
                  ((ex_rd_q == bus.id_rs) | (ex_rd_q == bus.id_rt));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      // Regfile write this cycle is not yet visible on the read port: bypass it.
      assign byp_data[gi] = (bus.memwb_reg_write && (bus.memwb_rd != R0) &&
                             (bus.memwb_rd == src_idx[gi])) ? bus.memwb_data
                                                            : src_data[gi];
      // Current EX moves to EX/MEM next cycle; it is younger, so checked first.
      assign fwd_sel[gi] =
        (ex_valid_q && ex_reg_write_q && (ex_rd_q != R0) && (ex_rd_q == src_idx[gi])) ? SEL_EXMEM :
        (bus.exmem_reg_write && (bus.exmem_rd != R0) && (bus.exmem_rd == src_idx[gi])) ? SEL_MEMWB :
        SEL_REG;
    end
  endgenerate

  // Next-state selection: flush > stall > load-use bubble > load from ID.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_rd_d        = ex_rd_q;
    ex_rs_data_d   = ex_rs_data_q;
    ex_rt_data_d   = ex_rt_data_q;
    ex_imm_d       = ex_imm_q;
    ex_fwd_a_sel_d = ex_fwd_a_sel_q;
    ex_fwd_b_sel_d = ex_fwd_b_sel_q;
    if (bus.flush || (!bus.stall && hazard)) begin
      ex_valid_d     = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_rd_d        = '0;
      ex_rs_data_d   = '0;
      ex_rt_data_d   = '0;
      ex_imm_d       = '0;
      ex_fwd_a_sel_d = SEL_REG;
      ex_fwd_b_sel_d = SEL_REG;
    end else if (!bus.stall) begin
      ex_valid_d     = bus.id_valid;
      ex_reg_write_d = bus.id_reg_write & bus.id_valid;
      ex_mem_read_d  = bus.id_mem_read & bus.id_valid;
      ex_rd_d        = bus.id_rd;
      ex_rs_data_d   = byp_data[0];
      ex_rt_data_d   = byp_data[1];
      ex_imm_d       = bus.id_imm;
      ex_fwd_a_sel_d = fwd_sel[0];
      ex_fwd_b_sel_d = fwd_sel[1];
    end
  end

  // EX-stage state register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_rd_q        <= '0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_imm_q       <= '0;
      ex_fwd_a_sel_q <= SEL_REG;
      ex_fwd_b_sel_q <= SEL_REG;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs_data_q   <= ex_rs_data_d;
      ex_rt_data_q   <= ex_rt_data_d;
      ex_imm_q       <= ex_imm_d;
      ex_fwd_a_sel_q <= ex_fwd_a_sel_d;
      ex_fwd_b_sel_q <= ex_fwd_b_sel_d;
    end
  end

  assign bus.ex_valid        = ex_valid_q;
  assign bus.ex_reg_write    = ex_reg_write_q;
  assign bus.ex_mem_read     = ex_mem_read_q;
  assign bus.ex_rd           = ex_rd_q;
  assign bus.ex_rs_data      = ex_rs_data_q;
  assign bus.ex_rt_data      = ex_rt_data_q;
  assign bus.ex_imm          = ex_imm_q;
  assign bus.ex_fwd_a_sel    = ex_fwd_a_sel_q;
  assign bus.ex_fwd_b_sel    = ex_fwd_b_sel_q;
  assign bus.load_use_hazard = hazard;

endmodule

// File: tb/tb_id_ex_fwd_reg.sv
// Directed bench for id_ex_fwd_reg: reset, forwarding selects, load-use
// bubble, WB bypass, stall and flush.
module tb_id_ex_fwd_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_ex_fwd_reg_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_fwd_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
    step();
    step();
    check("reset_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    check("reset_a_sel", {30'b0, bus.ex_fwd_a_sel}, 32'd0);
    rst = 1'b0;

    // 1. reset while EX is valid clears outputs without a clock edge
    bus.id_valid = 1; bus.id_rd = 3; bus.id_reg_write = 1; bus.id_rs = 1; bus.id_rt = 2;
    bus.id_imm = 32'hCAFE0001;
    step();
    check("load_ex_valid", {31'b0, bus.ex_valid}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    check("async_rst_ex_rd", {27'b0, bus.ex_rd}, 32'd0);
    check("async_rst_ex_imm", bus.ex_imm, 32'd0);
    check("async_rst_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
    #1 rst = 1'b0;
    step();
    check("post_rst_ex_valid", {31'b0, bus.ex_valid}, 32'd1);
    check("post_rst_ex_rd", {27'b0, bus.ex_rd}, 32'd3);

    // 2. back-to-back dependency on r3, younger EX beats EX/MEM
    bus.id_rs = 3; bus.id_rt = 3; bus.id_rd = 6; bus.id_reg_write = 0;
    bus.exmem_rd = 3; bus.exmem_reg_write = 1;
    step();
    check("b2b_a_sel", {30'b0, bus.ex_fwd_a_sel}, 32'd1);
    check("b2b_b_sel", {30'b0, bus.ex_fwd_b_sel}, 32'd1);
    check("b2b_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);

    // 3. distance-two dependency: put rd=7 in EX first
    bus.id_rd = 7; bus.id_reg_write = 1; bus.id_rs = 0; bus.id_rt = 0; bus.exmem_reg_write = 0;
    step();
    bus.id_rs = 4; bus.id_rt = 9; bus.exmem_rd = 4; bus.exmem_reg_write = 1;
    bus.id_rd = 10; bus.id_reg_write = 1;
    step();
    check("dist2_a_sel", {30'b0, bus.ex_fwd_a_sel}, 32'd2);
    check("dist2_b_sel", {30'b0, bus.ex_fwd_b_sel}, 32'd0);
    bus.id_rs = 0; bus.exmem_rd = 0; bus.id_rd = 0;
    step();
    check("r0_exmem_a_sel", {30'b0, bus.ex_fwd_a_sel}, 32'd0);
    // EX now writes r0 with reg_write=1; r0 must still not forward
    bus.id_rt = 0; bus.exmem_reg_write = 0;
    step();
    check("r0_ex_a_sel", {30'b0, bus.ex_fwd_a_sel}, 32'd0);
    check("r0_ex_b_sel", {30'b0, bus.ex_fwd_b_sel}, 32'd0);

    // 4. load-use: load r5 into EX, dependent instruction in ID
    bus.id_rd = 5; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rs = 0; bus.id_rt = 0;
    step();
    check("load_in_ex_mem_read", {31'b0, bus.ex_mem_read}, 32'd1);
    bus.id_rs = 5; bus.id_rt = 1; bus.id_rd = 11; bus.id_mem_read = 0;
    #1;
    check("lu_hazard_high", {31'b0, bus.load_use_hazard}, 32'd1);
    step();
    check("lu_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
    check("lu_bubble_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
    check("lu_bubble_rd", {27'b0, bus.ex_rd}, 32'd0);
    check("lu_hazard_low", {31'b0, bus.load_use_hazard}, 32'd0);
    bus.exmem_rd = 5; bus.exmem_reg_write = 1;
    step();
    check("lu_dep_valid", {31'b0, bus.ex_valid}, 32'd1);
    check("lu_dep_a_sel", {30'b0, bus.ex_fwd_a_sel}, 32'd2);
    check("lu_dep_b_sel", {30'b0, bus.ex_fwd_b_sel}, 32'd0);
    check("lu_dep_rd", {27'b0, bus.ex_rd}, 32'd11);

    // 5. WB bypass into captured operands
    bus.exmem_reg_write = 0;
    bus.id_rs = 8; bus.id_rs_data = 32'h11111111; bus.id_rt = 2; bus.id_rt_data = 32'h22222222;
    bus.memwb_rd = 8; bus.memwb_reg_write = 1; bus.memwb_data = 32'hDEADBEEF;
    bus.id_imm = 32'h12345678;
    step();
    check("wb_byp_rs", bus.ex_rs_data, 32'hDEADBEEF);
    check("wb_byp_rt_none", bus.ex_rt_data, 32'h22222222);
    check("imm_capture", bus.ex_imm, 32'h12345678);
    bus.id_rs = 0; bus.memwb_rd = 0;
    step();
    check("wb_byp_r0_rs", bus.ex_rs_data, 32'h11111111);
    bus.id_rs = 8; bus.memwb_rd = 8; bus.memwb_reg_write = 0;
    step();
    check("wb_byp_no_we", bus.ex_rs_data, 32'h11111111);
    bus.id_rt = 8; bus.memwb_reg_write = 1;
    step();
    check("wb_byp_rt", bus.ex_rt_data, 32'hDEADBEEF);
    check("wb_byp_rs_again", bus.ex_rs_data, 32'hDEADBEEF);

    // 6. stall holds state for 3 edges, then flush overrides stall
    bus.memwb_reg_write = 0;
    bus.id_rd = 12; bus.id_rs = 1; bus.id_rt = 2; bus.id_rs_data = 32'hAAAA0001;
    bus.id_rt_data = 32'hBBBB0002; bus.id_imm = 32'hCCCC0003; bus.id_reg_write = 1;
    bus.exmem_rd = 2; bus.exmem_reg_write = 1;
    step();
    check("pre_stall_b_sel", {30'b0, bus.ex_fwd_b_sel}, 32'd2);
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      bus.id_rd = 5'(13 + i); bus.id_rs_data = 32'h5 + i; bus.id_valid = 0; bus.exmem_reg_write = 0;
      step();
      check("stall_ex_valid", {31'b0, bus.ex_valid}, 32'd1);
      check("stall_ex_rd", {27'b0, bus.ex_rd}, 32'd12);
      check("stall_rs_data", bus.ex_rs_data, 32'hAAAA0001);
      check("stall_b_sel", {30'b0, bus.ex_fwd_b_sel}, 32'd2);
    end
    bus.flush = 1;
    step();
    check("flush_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    check("flush_a_sel", {30'b0, bus.ex_fwd_a_sel}, 32'd0);
    check("flush_b_sel", {30'b0, bus.ex_fwd_b_sel}, 32'd0);
    check("flush_rs_data", bus.ex_rs_data, 32'd0);
    check("flush_ex_rd", {27'b0, bus.ex_rd}, 32'd0);

    // invalid ID instruction: write/load flags gated by valid
    bus.flush = 0; bus.stall = 0;
    bus.id_valid = 0; bus.id_reg_write = 1; bus.id_mem_read = 1;
    step();
    check("inv_ex_valid", {31'b0, bus.ex_valid}, 32'd0);
    check("inv_reg_write", {31'b0, bus.ex_reg_write}, 32'd0);
    check("inv_mem_read", {31'b0, bus.ex_mem_read}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_fwd_reg.md
Name: id_ex_fwd_reg

Overview:
ID/EX pipeline register for the 32-bit core.
- Latches decoded operands and control from ID into EX.
- Generates the registered 2-bit select codes for the EX-stage 3:1 operand forwarding muxes.
- Performs the WB-to-ID same-cycle register-file bypass.
- Detects load-use hazards and inserts a bubble into EX on its own.

Parameters:
DATA_WIDTH, 32, operand/immediate width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  external freeze; hold all state
flush  in  1  squash ID/EX contents (branch/exception)
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_ADDR_WIDTH  source A index
id_rt  in  REG_ADDR_WIDTH  source B index
id_rd  in  REG_ADDR_WIDTH  destination index
id_rs_data  in  DATA_WIDTH  regfile read A
id_rt_data  in  DATA_WIDTH  regfile read B
id_imm  in  DATA_WIDTH  sign-extended immediate
id_reg_write  in  1  instruction writes rd
id_mem_read  in  1  instruction is a load
exmem_reg_write  in  1  EX/MEM instruction writes a register
exmem_rd  in  REG_ADDR_WIDTH  EX/MEM destination
memwb_reg_write  in  1  MEM/WB writes regfile this cycle
memwb_rd  in  REG_ADDR_WIDTH  MEM/WB destination
memwb_data  in  DATA_WIDTH  MEM/WB write data
ex_valid  out  1  EX holds a real instruction
ex_rs_data  out  DATA_WIDTH  latched operand A
ex_rt_data  out  DATA_WIDTH  latched operand B
ex_imm  out  DATA_WIDTH  latched immediate
ex_rd  out  REG_ADDR_WIDTH  latched destination
ex_reg_write  out  1  latched write enable, gated by valid
ex_mem_read  out  1  latched load flag, gated by valid
ex_fwd_a_sel  out  2  mux select for A: 00 reg, 01 EX/MEM, 10 MEM/WB
ex_fwd_b_sel  out  2  same encoding for B
load_use_hazard  out  1  combinational; upstream must hold PC and IF/ID

Behaviour:
Reset:
- rst high clears every registered output to 0 immediately and asynchronously (ex_valid=0, sels=00, data=0).
- No state survives reset mid-operation.

Hazard detection (combinational):
- load_use_hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt).

Per-edge priority (highest first):
1. flush: load a bubble. ex_valid=0, ex_reg_write=0, ex_mem_read=0, sels=00, data fields=0. Flush overrides stall.
2. stall: hold every register unchanged.
3. load_use_hazard: load a bubble, same as flush.
4. Otherwise: load ID. ex_valid=id_valid; ex_reg_write=id_reg_write&id_valid; ex_mem_read=id_mem_read&id_valid; ex_rd, ex_imm copied.

Operand capture with WB bypass:
- ex_rs_data = memwb_data if memwb_reg_write & memwb_rd!=0 & memwb_rd==id_rs; else id_rs_data.
- ex_rt_data is computed the same way using id_rt.

Forwarding select, computed at load time for source A (rs); B (rt) is identical:
- 01 if ex_valid & ex_reg_write & ex_rd!=0 & ex_rd==id_rs. The current EX instruction will sit in EX/MEM next cycle.
- else 10 if exmem_reg_write & exmem_rd!=0 & exmem_rd==id_rs. It will sit in MEM/WB next cycle.
- else 00.
- When both match, the younger instruction (current EX) wins.
- Register 0 never forwards.
- Code 11 is never produced.

Latency and sequencing:
- One cycle from ID inputs to ex_* outputs.
- A load-use case costs exactly one bubble. On the following edge the load is in EX/MEM and the bubble is in EX, so the dependent instruction latches sel=10.

Test Plan:
1. Reset: assert rst mid-cycle with ex_valid=1 -> all outputs 0 immediately without a clock edge; after release and one edge with id_valid=1, rd=3 -> ex_valid=1, ex_rd=3.
2. Back-to-back dependency: edge 1 loads add r3 (reg_write=1); edge 2 loads id_rs=3, id_rt=3 with exmem_rd=3, exmem_reg_write=1 -> ex_fwd_a_sel=ex_fwd_b_sel=01 (younger wins).
3. Distance-two dependency: EX holds rd=7; ID has rs=4, rt=9; exmem_rd=4, exmem_reg_write=1 -> a_sel=10, b_sel=00. Repeat with rs=0, exmem_rd=0 -> a_sel=00.
4. Load-use: EX holds a load with rd=5; ID has rs=5 -> load_use_hazard=1 and next edge ex_valid=0, ex_reg_write=0. Next edge with exmem_rd=5, exmem_reg_write=1 -> ex_valid=1, a_sel=10.
5. WB bypass: id_rs=8, id_rs_data=0x11111111, memwb_rd=8, memwb_reg_write=1, memwb_data=0xDEADBEEF -> ex_rs_data=0xDEADBEEF. Same with memwb_rd=0 -> 0x11111111.
6. Stall/flush: with valid contents, stall=1 for 3 edges while ID inputs change -> outputs unchanged. stall=1 and flush=1 on the same edge -> ex_valid=0, sels=00.
